pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register: the successor to the fixed-width stall/flush stage registers between the CPU pipeline stages (IF/ID and later). It carries an arbitrary-width payload with a valid/ready handshake on both sides, and a two-entry skid buffer so that upstream `ready_o` never depends combinationally on downstream `ready_i`. It supports synchronous flush to a programmable bubble value, plus saturating stall and flush event counters for performance debug.

---
 rtl/pipe_skid_reg.sv | 123 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush to a bubble value and saturating stall/flush counters.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  m_q, m_d;
  logic [DATA_W-1:0]  s_q, s_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               in_fire;
  logic               out_fire;

  // Handshake outputs come straight from the state flops, so ready_o never
  // sees a combinational path from ready_i.
  assign valid_o  = (state_q != ST_EMPTY);
  assign ready_o  = (state_q != ST_SKID);
  assign data_o   = m_q;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      m_d     = FLUSH_VAL;
      s_d     = FLUSH_VAL;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            m_d     = data_i;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            m_d = data_i;
          end else if (in_fire) begin
            state_d = ST_SKID;
            s_d     = data_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            m_d     = FLUSH_VAL;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d = ST_FULL;
            m_d     = s_q;
            s_d     = FLUSH_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_d     = FLUSH_VAL;
          s_d     = FLUSH_VAL;
        end
      endcase
    end
  end

  // Counters saturate at all-ones; a clear overrides a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (valid_o && !ready_i && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_i && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_EMPTY;
      m_q         <= FLUSH_VAL;
      s_q         <= FLUSH_VAL;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a queue-based reference of the stage
// predicts handshake, payload order, flush drops and counter values.
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W    = 32;
  localparam logic [31:0] FLUSH_VAL = 32'hDEAD_BEEF;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk_i;
  logic              rst_n_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic              clr_cnt_i;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  int vec_count = 0;
  int err_count = 0;

  logic [31:0] exp_q[$];
  int          stall_m = 0;
  int          flush_m = 0;
  logic        acc;

  pipe_skid_reg #(
    .DATA_W   (DATA_W),
    .FLUSH_VAL(FLUSH_VAL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .clr_cnt_i  (clr_cnt_i),
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("valid_o", 32'(valid_o), 32'(exp_q.size() > 0));
    checkOutput("ready_o", 32'(ready_o), 32'(exp_q.size() < 2));
    checkOutput("data_o", data_o, (exp_q.size() > 0) ? exp_q[0] : FLUSH_VAL);
    checkOutput("stall_cnt", 32'(stall_cnt_o), 32'(stall_m));
    checkOutput("flush_cnt", 32'(flush_cnt_o), 32'(flush_m));
  endtask

  // One clock cycle: drive inputs, compare outputs against the reference,
  // then advance the reference across the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy,
                               input logic fl, input logic clr, output logic accepted);
    logic m_valid;
    logic m_ready;
    logic out_ok;
    valid_i   = v;
    data_i    = d;
    ready_i   = rdy;
    flush_i   = fl;
    clr_cnt_i = clr;
    #1;
    checkModel();
    m_valid  = exp_q.size() > 0;
    m_ready  = exp_q.size() < 2;
    accepted = v & m_ready;
    out_ok   = m_valid & rdy;
    @(posedge clk_i);
    if (clr) begin
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (m_valid && !rdy && stall_m < CNT_MAX) stall_m++;
      if (fl && flush_m < CNT_MAX) flush_m++;
    end
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_ok) void'(exp_q.pop_front());
      if (accepted) exp_q.push_back(d);
    end
    @(negedge clk_i);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_ready"}, 32'(ready_o), 32'd1);
    checkOutput({tag, "_data"}, data_o, FLUSH_VAL);
    checkOutput({tag, "_stall"}, 32'(stall_cnt_o), 32'd0);
    checkOutput({tag, "_flush"}, 32'(flush_cnt_o), 32'd0);
  endtask

  initial begin
    rst_n_i   = 1'b1;
    valid_i   = 1'b1;
    data_i    = 32'h77;
    ready_i   = 1'b0;
    flush_i   = 1'b0;
    clr_cnt_i = 1'b0;

    // Reset with valid_i high
    #2 rst_n_i = 1'b0;
    #1 checkResetValues("rst");
    @(negedge clk_i);
    @(negedge clk_i);
    checkResetValues("rst_hold");
    rst_n_i = 1'b1;

    applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("a5_data", data_o, 32'hA5);
    checkOutput("a5_valid", 32'(valid_o), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, acc);
      checkOutput("stream_data", data_o, 32'(i));
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("stream_stall", 32'(stall_cnt_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Backpressure into the skid entry
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("skid_ready", 32'(ready_o), 32'd0);
    checkOutput("skid_m", data_o, 32'h1);
    checkOutput("skid_stall", 32'(stall_cnt_o), 32'd5);
    acc = 1'b0;
    for (int i = 0; i < 6 && !acc; i++) applyStimulus(1'b1, 32'h3, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("skid_accept3", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Flush while SKID, no drain
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 32'hF01, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hF02, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hF03, 1'b0, 1'b1, 1'b0, acc);
    checkResetValues_flush(1);

    // Flush from FULL with same-cycle in_fire and out_fire
    applyStimulus(1'b1, 32'hE01, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hE02, 1'b1, 1'b1, 1'b0, acc);
    checkResetValues_flush(2);

    // Flush while SKID with a draining out_fire
    applyStimulus(1'b1, 32'hD01, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hD02, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, acc);
    checkResetValues_flush(3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Counter saturation and clear during a stall
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("stall_sat", 32'(stall_cnt_o), 32'd15);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("stall_clr", 32'(stall_cnt_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("stall_resume", 32'(stall_cnt_o), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Randomised traffic against the reference
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 23) == 0, acc);
    end

    // Asynchronous reset in the middle of a transfer
    applyStimulus(1'b1, 32'hC01, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hC02, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 32'hC03, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hC04, 1'b0, 1'b0, 1'b0, acc);
    #2 rst_n_i = 1'b0;
    #1 checkResetValues("midrst");
    exp_q.delete();
    stall_m = 0;
    flush_m = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    applyStimulus(1'b1, 32'hB0, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  task automatic checkResetValues_flush(input int exp_flush);
    checkOutput("flush_valid", 32'(valid_o), 32'd0);
    checkOutput("flush_ready", 32'(ready_o), 32'd1);
    checkOutput("flush_data", data_o, FLUSH_VAL);
    checkOutput("flush_count", 32'(flush_cnt_o), 32'(exp_flush));
  endtask

endmodule
